// File: rtl/mem_store_unit_pkg.sv
// mem_store_unit_pkg: shared MemWriteType encodings and store FSM states
package mem_store_unit_pkg;
  localparam logic [1:0] MW_BYTE = 2'b00;
  localparam logic [1:0] MW_HALF = 2'b01;
  localparam logic [1:0] MW_WORD = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
endpackage

// File: rtl/mem_store_unit_store_formatter.sv
// store_formatter: lane replication, byte strobes, bus size and misalignment for one store
// Ports: type_i (MemWriteType, 11 acts as word), addr_lo_i (addr[1:0]), data_i (right-justified),
//        wdata_o, wstrb_o, size_o (0 byte/1 half/2 word), misaligned_o
module store_formatter
  import mem_store_unit_pkg::*;
(
  input  logic [1:0]  type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [1:0]  size_o,
  output logic        misaligned_o
);
  always_comb begin
    wdata_o      = type_i == MW_BYTE ? {4{data_i[7:0]}} : type_i == MW_HALF ? {2{data_i[15:0]}} : data_i;
    wstrb_o      = type_i == MW_BYTE ? 4'b0001 << addr_lo_i : type_i == MW_HALF ? (addr_lo_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    size_o       = type_i == MW_BYTE ? 2'd0 : type_i == MW_HALF ? 2'd1 : 2'd2;
    misaligned_o = type_i == MW_BYTE ? 1'b0 : type_i == MW_HALF ? addr_lo_i[0] : |addr_lo_i;
  end
endmodule

// File: rtl/mem_store_unit.sv
// mem_store_unit: MEM-stage store path driving one store at a time onto the sram-like data bus
// Ports: clk/resetn; MemWriteM, MemWriteTypeM, addrM, wdataM, flush from MEM;
//        data_req/wr/size/addr/wdata/wstrb to bus, data_addr_ok/data_data_ok from bus;
//        stall to pipeline, store_addr_err pulse and BadVAddr for AdES
module mem_store_unit
  import mem_store_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             MemWriteM,
  input  logic [1:0]       MemWriteTypeM,
  input  logic [WIDTH-1:0] addrM,
  input  logic [WIDTH-1:0] wdataM,
  input  logic             flush,
  output logic             data_req,
  output logic             data_wr,
  output logic [1:0]       data_size,
  output logic [WIDTH-1:0] data_addr,
  output logic [WIDTH-1:0] data_wdata,
  output logic [3:0]       data_wstrb,
  input  logic             data_addr_ok,
  input  logic             data_data_ok,
  output logic             stall,
  output logic             store_addr_err,
  output logic [WIDTH-1:0] BadVAddr
);
  state_e           state_q;
  logic             req_q, wr_q, err_q, mis;
  logic [1:0]       size_q, fmt_size;
  logic [3:0]       wstrb_q, fmt_wstrb;
  logic [WIDTH-1:0] addr_q, wdata_q, badv_q, fmt_wdata;
  store_formatter u_fmt (
    .type_i      (MemWriteTypeM),
    .addr_lo_i   (addrM[1:0]),
    .data_i      (wdataM),
    .wdata_o     (fmt_wdata),
    .wstrb_o     (fmt_wstrb),
    .size_o      (fmt_size),
    .misaligned_o(mis)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      badv_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: if (MemWriteM && !flush) begin
          if (mis) begin
            err_q  <= 1'b1;
            badv_q <= addrM;
          end else begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            wr_q    <= 1'b1;
            size_q  <= fmt_size;
            wstrb_q <= fmt_wstrb;
            addr_q  <= addrM;
            wdata_q <= fmt_wdata;
          end
        end
        // once the address is accepted the write cannot be retracted, so flush is not consulted here
        S_REQ: if (data_addr_ok) begin
          req_q   <= 1'b0;
          wr_q    <= 1'b0;
          state_q <= data_data_ok ? S_DONE : S_WAIT;
        end
        S_WAIT: if (data_data_ok) state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  // stall rises combinationally in the capture cycle so MEM holds the store until DONE
  assign stall = (state_q == S_IDLE && MemWriteM && !mis && !flush) || state_q == S_REQ || state_q == S_WAIT;
  assign data_req       = req_q;
  assign data_wr        = wr_q;
  assign data_size      = size_q;
  assign data_addr      = addr_q;
  assign data_wdata     = wdata_q;
  assign data_wstrb     = wstrb_q;
  assign store_addr_err = err_q;
  assign BadVAddr       = badv_q;
endmodule

// File: tb/tb_mem_store_unit.sv
// tb_mem_store_unit: directed and randomized store checks against an arithmetic reference model
module tb_mem_store_unit;
  logic        clk = 1'b0, resetn = 1'b0;
  logic        MemWriteM = 1'b0, flush = 1'b0, data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [1:0]  MemWriteTypeM = '0;
  logic [31:0] addrM = '0, wdataM = '0;
  logic        data_req, data_wr, stall, store_addr_err;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, BadVAddr;
  logic [3:0]  data_wstrb;
  int          n_assert = 0, n_fail = 0;
  logic [31:0] exp_q[$], acc_q[$];
  mem_store_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .MemWriteM(MemWriteM), .MemWriteTypeM(MemWriteTypeM),
    .addrM(addrM), .wdataM(wdataM), .flush(flush), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .stall(stall),
    .store_addr_err(store_addr_err), .BadVAddr(BadVAddr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (resetn && data_req && data_addr_ok) acc_q.push_back(data_addr);
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] w, output logic [3:0] s, output logic [1:0] sz, output logic mis);
    int nb;
    nb  = t == 2'd0 ? 1 : t == 2'd1 ? 2 : 4;
    mis = (a % nb) != 0;
    sz  = nb == 1 ? 2'd0 : nb == 2 ? 2'd1 : 2'd2;
    w   = nb == 1 ? d[7:0] * 32'h0101_0101 : nb == 2 ? d[15:0] * 32'h0001_0001 : d;
    s   = 4'(((1 << nb) - 1) << (a % 4));
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                       input int adly, input int ddly, input bit fl_wait);
    logic [31:0] w;
    logic [3:0]  s;
    logic [1:0]  sz;
    logic        mis;
    model(t, a, d, w, s, sz, mis);
    MemWriteM = 1'b1; MemWriteTypeM = t; addrM = a; wdataM = d; flush = 1'b0;
    #1 check("stall_capture", stall, !mis);
    tick();
    if (mis) begin
      check("err_pulse", store_addr_err, 1'b1);
      check("badvaddr", BadVAddr, a);
      check("no_req_mis", data_req, 1'b0);
      check("no_stall_mis", stall, 1'b0);
      MemWriteM = 1'b0;
      tick();
      check("err_one_cycle", store_addr_err, 1'b0);
      check("no_req_after_mis", data_req, 1'b0);
    end else begin
      exp_q.push_back(a);
      check("req", data_req, 1'b1);
      check("wr", data_wr, 1'b1);
      check("addr", data_addr, a);
      check("wdata", data_wdata, w);
      check("wstrb", data_wstrb, s);
      check("size", data_size, sz);
      check("stall_req", stall, 1'b1);
      for (int i = 0; i < adly; i++) begin
        tick();
        check("req_held", data_req, 1'b1);
        check("addr_held", data_addr, a);
        check("wdata_held", data_wdata, w);
        check("stall_held", stall, 1'b1);
      end
      data_addr_ok = 1'b1; data_data_ok = ddly == 0;
      tick();
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      if (ddly > 0) begin
        flush = fl_wait;
        check("req_drop", data_req, 1'b0);
        check("stall_wait", stall, 1'b1);
        for (int i = 1; i < ddly; i++) begin
          tick();
          check("stall_wait2", stall, 1'b1);
          check("req_wait2", data_req, 1'b0);
        end
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0; flush = 1'b0;
      end
      check("stall_done", stall, 1'b0);
      check("req_done", data_req, 1'b0);
      tick();
      MemWriteM = 1'b0;
      check("req_idle", data_req, 1'b0);
    end
  endtask
  initial begin
    tick();
    check("rst_req", data_req, 1'b0);
    check("rst_wr", data_wr, 1'b0);
    check("rst_wdata", data_wdata, 32'h0);
    check("rst_badv", BadVAddr, 32'h0);
    check("rst_stall", stall, 1'b0);
    resetn = 1'b1;
    tick();
    store(2'd0, 32'h1003, 32'h0000_00A5, 0, 0, 0);
    store(2'd1, 32'h2002, 32'h1234_BEEF, 3, 2, 0);
    store(2'd2, 32'h3001, 32'hDEAD_BEEF, 0, 0, 0);
    MemWriteM = 1'b1; MemWriteTypeM = 2'd2; addrM = 32'h4000; flush = 1'b1;
    #1 check("flush_idle_stall", stall, 1'b0);
    tick();
    check("flush_idle_req", data_req, 1'b0);
    check("flush_idle_err", store_addr_err, 1'b0);
    MemWriteM = 1'b0; flush = 1'b0;
    tick();
    check("flush_idle_req2", data_req, 1'b0);
    store(2'd2, 32'h4000, 32'hCAFE_F00D, 1, 3, 1);
    MemWriteM = 1'b1; MemWriteTypeM = 2'd2; addrM = 32'h5000; wdataM = 32'h5555_AAAA;
    tick();
    exp_q.push_back(32'h5000);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; MemWriteM = 1'b0; resetn = 1'b0;
    #1;
    check("rst_wait_req", data_req, 1'b0);
    check("rst_wait_wr", data_wr, 1'b0);
    check("rst_wait_size", data_size, 2'd0);
    check("rst_wait_addr", data_addr, 32'h0);
    check("rst_wait_wdata", data_wdata, 32'h0);
    check("rst_wait_wstrb", data_wstrb, 4'h0);
    check("rst_wait_stall", stall, 1'b0);
    tick();
    resetn = 1'b1;
    tick();
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    check("late_dok_req", data_req, 1'b0);
    check("late_dok_stall", stall, 1'b0);
    tick();
    check("late_dok_req2", data_req, 1'b0);
    store(2'd2, 32'h6000, 32'h0102_0304, 0, 1, 0);
    store(2'd2, 32'h10, 32'h1111_1111, 0, 0, 0);
    store(2'd2, 32'h14, 32'h2222_2222, 1, 1, 0);
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      store(2'($urandom_range(0, 3)), ra, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    tick();
    check("accept_count", acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) check("accept_addr", acc_q[i], exp_q[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
